pll_lock_sequencer: RTL

Reset and lock supervisor for the Gowin rPLL that generates the display pixel clock from the 27 MHz board oscillator. It runs on the 27 MHz reference clock, because the PLL output cannot be trusted before lock. It pulses the PLL reset, qualifies LOCK over a stability window, and releases the system reset for downstream logic. It retries on lock timeout and optionally reprograms the PLL dividers at runtime for a second video clock.

---
 rtl/pll_lock_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for the rPLL on the 27 MHz reference: pulses PLL reset, qualifies LOCK, releases sys_reset.
// Optional runtime A/B divider preset switching is compiled in with `define PLL_DYN_MODE_EN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter logic [5:0]  IDSEL_A      = 6'd61,
  parameter logic [5:0]  FBDSEL_A     = 6'd50,
  parameter logic [5:0]  ODSEL_A      = 6'd60,
  parameter logic [5:0]  IDSEL_B      = 6'd60,
  parameter logic [5:0]  FBDSEL_B     = 6'd53,
  parameter logic [5:0]  ODSEL_B      = 6'd56
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       fail,
  input  logic       mode_req,
  input  logic       mode_sel,
  output logic       mode_ack,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel
);
  localparam int unsigned RW = (RST_CYCLES > 1)   ? $clog2(RST_CYCLES)   : 1;
  localparam int unsigned SW = (LOCK_STABLE > 1)  ? $clog2(LOCK_STABLE)  : 1;
  localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned CW = (MAX_RETRIES > 0)  ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [1:0] {ST_RST_PLL, ST_WAIT_LOCK, ST_RUN, ST_FAIL} state_t;

  state_t        state_q;
  logic [RW-1:0] rst_cnt_q;
  logic [SW-1:0] stable_q;
  logic [TW-1:0] timeout_q;
  logic [CW-1:0] retry_q;
  logic          sync1_q;
  logic          lock_s_q;

  logic          lock_ok_c;
  logic          timeout_c;
  logic [CW-1:0] retry_inc_c;
  logic          to_run_c;
  logic          retry_out_c;
  logic          to_fail_c;
  logic          accept_c;

  // LOCK from a PLL held in reset is meaningless, so the synchronizer is kept clear meanwhile.
  always_ff @(posedge clkin) begin
    if (reset || pll_reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  assign lock_ok_c   = lock_s_q && (stable_q == SW'(LOCK_STABLE - 1));
  assign timeout_c   = (timeout_q == TW'(LOCK_TIMEOUT - 1));
  assign retry_inc_c = retry_q + CW'(1);
  assign to_run_c    = (state_q == ST_WAIT_LOCK) && lock_ok_c;
  assign retry_out_c = (state_q == ST_WAIT_LOCK) && !lock_ok_c && timeout_c;
  assign to_fail_c   = retry_out_c && (retry_inc_c == CW'(MAX_RETRIES));

`ifdef PLL_DYN_MODE_EN
  logic armed_q;
  logic pending_q;

  assign accept_c = mode_req && armed_q && ((state_q == ST_RUN) || (state_q == ST_FAIL));

  // Preset latch and request/ack handshake; armed_q tracks "req seen low since last ack".
  always_ff @(posedge clkin) begin
    if (reset) begin
      armed_q   <= 1'b1;
      pending_q <= 1'b0;
      mode_ack  <= 1'b0;
      idsel     <= IDSEL_A;
      fbdsel    <= FBDSEL_A;
      odsel     <= ODSEL_A;
    end else begin
      mode_ack <= 1'b0;
      if (accept_c) begin
        pending_q <= 1'b1;
        idsel     <= mode_sel ? IDSEL_B  : IDSEL_A;
        fbdsel    <= mode_sel ? FBDSEL_B : FBDSEL_A;
        odsel     <= mode_sel ? ODSEL_B  : ODSEL_A;
      end else if (pending_q && (to_run_c || to_fail_c)) begin
        pending_q <= 1'b0;
        mode_ack  <= 1'b1;
      end
      if (pending_q && (to_run_c || to_fail_c)) begin
        armed_q <= 1'b0;
      end else if (!mode_req) begin
        armed_q <= 1'b1;
      end
    end
  end
`else
  logic unused_mode;

  assign accept_c    = 1'b0;
  assign mode_ack    = 1'b0;
  assign idsel       = IDSEL_A;
  assign fbdsel      = FBDSEL_A;
  assign odsel       = ODSEL_A;
  assign unused_mode = ^{mode_req, mode_sel, IDSEL_B, FBDSEL_B, ODSEL_B};
`endif

  // Sequencer: state, counters and the four status outputs all update together.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= ST_RST_PLL;
      rst_cnt_q <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      retry_q   <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else if (accept_c) begin
      state_q   <= ST_RST_PLL;
      rst_cnt_q <= '0;
      retry_q   <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            state_q   <= ST_WAIT_LOCK;
            stable_q  <= '0;
            timeout_q <= '0;
            pll_reset <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_s_q) begin
            stable_q <= '0;
          end else if (stable_q != SW'(LOCK_STABLE - 1)) begin
            stable_q <= stable_q + SW'(1);
          end
          if (!timeout_c) begin
            timeout_q <= timeout_q + TW'(1);
          end
          if (to_run_c) begin
            state_q   <= ST_RUN;
            retry_q   <= '0;
            sys_reset <= 1'b0;
            locked    <= 1'b1;
          end else if (retry_out_c) begin
            state_q   <= to_fail_c ? ST_FAIL : ST_RST_PLL;
            retry_q   <= retry_inc_c;
            rst_cnt_q <= '0;
            pll_reset <= 1'b1;
            fail      <= to_fail_c;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_q   <= ST_RST_PLL;
            rst_cnt_q <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
          end
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q   <= ST_RST_PLL;
          rst_cnt_q <= '0;
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          locked    <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
